// File: rtl/lc2k_pkg.sv
// Shared encodings for the LC2K multi-cycle controller: opcodes, datapath
// mux selects and the sequencer state enum.
package lc2k_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NOR  = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_JALR = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_NOOP = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_NOR = 2'b01;
  localparam logic [1:0] ALU_CMP = 2'b10;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REGA   = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_ADDR,
    S_MEM, S_WB_MEM, S_BEQ, S_JALR, S_HALTED
  } state_t;

endpackage

// File: rtl/lc2k_mem_handshake.sv
// Memory req/ready tracking: flags a completed transfer and a wait timeout
// once a request has gone MEM_WAIT_MAX cycles without mem_ready.
module lc2k_mem_handshake #(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ready,
  output logic done,
  output logic timeout
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 2);

  logic [WAIT_W-1:0] wait_cnt;

  // Any cycle without an outstanding request (or a completed one) rearms the
  // counter, so every FETCH/MEM entry starts counting from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!req || ready) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign done = req && ready;

  // Fires on the MEM_WAIT_MAX-th consecutive non-ready cycle; ready wins.
  generate
    if (MEM_WAIT_MAX == 0) begin : g_no_timeout
      assign timeout = 1'b0;
    end else begin : g_timeout
      assign timeout = req && !ready && (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1));
    end
  endgenerate

endmodule

// File: rtl/lc2k_multicycle_ctrl.sv
// LC2K multi-cycle sequencer: steps each instruction through FETCH/DECODE/
// EXEC/MEM/WB, drives datapath selects/enables and owns halt and counters.
module lc2k_multicycle_ctrl
  import lc2k_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic             alu_eq,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             ab_we,
  output logic             aluout_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_srcb,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic             reg_dst_sel,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic             mem_fault,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count,
  output state_t           fsm_state
);

  state_t state, next_state;
  logic   retire;
  logic   mem_done, mem_timeout;

  // Memory-side outputs depend on state only, so they hold steady while waiting.
  assign mem_req      = (state == S_FETCH) || (state == S_MEM);
  assign mem_addr_sel = (state == S_MEM);
  assign mem_we       = (state == S_MEM) && (opcode == OP_SW);
  assign halted       = (state == S_HALTED);
  assign fsm_state    = state;

  lc2k_mem_handshake #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_hs (
    .clk     (clk),
    .reset   (reset),
    .req     (mem_req),
    .ready   (mem_ready),
    .done    (mem_done),
    .timeout (mem_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      instr_count <= '0;
      cycle_count <= '0;
      mem_fault   <= 1'b0;
    end else begin
      state <= next_state;
      if (retire) instr_count <= instr_count + 1'b1;
      if (state != S_IDLE && state != S_HALTED) cycle_count <= cycle_count + 1'b1;
      if (mem_timeout) mem_fault <= 1'b1;
    end
  end

  always_comb begin
    next_state  = state;
    ir_we       = 1'b0;
    ab_we       = 1'b0;
    aluout_we   = 1'b0;
    mdr_we      = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PC_INC;
    alu_srcb    = 1'b0;
    alu_op      = ALU_ADD;
    reg_we      = 1'b0;
    reg_dst_sel = 1'b0;
    wb_sel      = WB_ALUOUT;
    retire      = 1'b0;
    case (state)
      S_IDLE: if (start) next_state = S_FETCH;
      S_FETCH: begin
        if (mem_done) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          next_state = S_DECODE;
        end else if (mem_timeout) begin
          next_state = S_HALTED;
        end
      end
      S_DECODE: begin
        ab_we = 1'b1;
        case (opcode)
          OP_ADD, OP_NOR: next_state = S_EXEC;
          OP_LW, OP_SW:   next_state = S_ADDR;
          OP_BEQ:         next_state = S_BEQ;
          OP_JALR:        next_state = S_JALR;
          OP_HALT: begin
            retire     = 1'b1;
            next_state = S_HALTED;
          end
          default: begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        alu_srcb   = 1'b1;
        alu_op     = (opcode == OP_NOR) ? ALU_NOR : ALU_ADD;
        aluout_we  = 1'b1;
        next_state = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_we      = 1'b1;
        reg_dst_sel = 1'b1;
        retire      = 1'b1;
        next_state  = S_FETCH;
      end
      S_ADDR: begin
        aluout_we  = 1'b1;
        next_state = S_MEM;
      end
      S_MEM: begin
        if (mem_done) begin
          if (opcode == OP_SW) begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end else begin
            mdr_we     = 1'b1;
            next_state = S_WB_MEM;
          end
        end else if (mem_timeout) begin
          next_state = S_HALTED;
        end
      end
      S_WB_MEM: begin
        reg_we     = 1'b1;
        wb_sel     = WB_MDR;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ: begin
        alu_srcb   = 1'b1;
        alu_op     = ALU_CMP;
        pc_src     = PC_BRANCH;
        pc_we      = alu_eq;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      // PC already holds PC+1 from FETCH; regA comes from the A latch, so the
      // jump target is the pre-write value even when regA==regB.
      S_JALR: begin
        reg_we     = 1'b1;
        wb_sel     = WB_PC;
        pc_src     = PC_REGA;
        pc_we      = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_IDLE;
    endcase
  end

endmodule
